// File: rtl/capture_ctrl.sv
// Camera capture sequencer: debounced start, optional framebuffer clear,
// vsync-framed pixel forwarding to the framebuffer write port, frame status.
module capture_ctrl #(
  parameter int unsigned AW      = 15,
  parameter int unsigned NPIX    = 19200,
  parameter int unsigned DB_CYC  = 16,
  parameter logic [7:0]  CLR_VAL = 8'h00
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          btn,
  input  logic          cont,
  input  logic          clr_en,
  input  logic          vsync,
  input  logic          cam_wr,
  input  logic [AW-1:0] cam_addr,
  input  logic [7:0]    cam_data,
  output logic          cam_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          busy,
  output logic          frame_done,
  output logic          short_frame,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned CW  = AW + 1;
  localparam int unsigned DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0]  NPIX_C  = CW'(NPIX);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_VS, S_CAPTURE, S_DONE
  } state_t;

  state_t          state, state_n;
  logic            btn_s1, btn_s2, db_lvl, start;
  logic [DBW-1:0]  db_cnt;
  logic            vs_d, vs_fall, vs_rise;
  logic [CW-1:0]   clr_addr, clr_addr_n;
  logic [CW-1:0]   px_cnt, px_cnt_n, px_inc;
  logic            accept;
  logic            cam_en_n, mem_wr_n, busy_n, frame_done_n, short_frame_n;
  logic [AW-1:0]   mem_addr_n;
  logic [7:0]      mem_data_n, frame_cnt_n;

  // Button synchronizer, debouncer and rising-edge start pulse
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      db_lvl <= 1'b0;
      db_cnt <= '0;
      start  <= 1'b0;
      vs_d   <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      vs_d   <= vsync;
      start  <= 1'b0;
      if (btn_s2 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_lvl <= btn_s2;
        db_cnt <= '0;
        start  <= btn_s2;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign vs_fall = vs_d & ~vsync;
  assign vs_rise = ~vs_d & vsync;
  assign accept  = cam_wr && (CW'(cam_addr) < NPIX_C);
  assign px_inc  = px_cnt + CW'(accept);

  // State register and registered outputs
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      clr_addr    <= '0;
      px_cnt      <= '0;
      cam_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      clr_addr    <= clr_addr_n;
      px_cnt      <= px_cnt_n;
      cam_en      <= cam_en_n;
      mem_wr      <= mem_wr_n;
      mem_addr    <= mem_addr_n;
      mem_data    <= mem_data_n;
      busy        <= busy_n;
      frame_done  <= frame_done_n;
      short_frame <= short_frame_n;
      frame_cnt   <= frame_cnt_n;
    end
  end

  // Next-state and next-output logic; the first clear write is issued on entry
  always_comb begin
    state_n       = state;
    clr_addr_n    = clr_addr;
    px_cnt_n      = px_cnt;
    mem_wr_n      = 1'b0;
    mem_addr_n    = mem_addr;
    mem_data_n    = mem_data;
    frame_done_n  = 1'b0;
    short_frame_n = short_frame;
    frame_cnt_n   = frame_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (clr_en) begin
            state_n    = S_CLEAR;
            mem_wr_n   = 1'b1;
            mem_addr_n = '0;
            mem_data_n = CLR_VAL;
            clr_addr_n = CW'(1);
          end else begin
            state_n = S_WAIT_VS;
          end
        end
      end
      S_CLEAR: begin
        if (start) begin
          state_n = S_IDLE;
        end else if (clr_addr == NPIX_C) begin
          state_n = S_WAIT_VS;
        end else begin
          mem_wr_n   = 1'b1;
          mem_addr_n = clr_addr[AW-1:0];
          mem_data_n = CLR_VAL;
          clr_addr_n = clr_addr + CW'(1);
        end
      end
      S_WAIT_VS: begin
        if (start) begin
          state_n = S_IDLE;
        end else if (vs_fall) begin
          state_n  = S_CAPTURE;
          px_cnt_n = '0;
        end
      end
      S_CAPTURE: begin
        if (start) begin
          state_n = S_IDLE;
        end else begin
          if (accept) begin
            mem_wr_n   = 1'b1;
            mem_addr_n = cam_addr;
            mem_data_n = cam_data;
            px_cnt_n   = px_inc;
          end
          // A full count wins over a coincident vsync rise
          if (px_inc == NPIX_C || vs_rise) begin
            state_n       = S_DONE;
            frame_done_n  = 1'b1;
            short_frame_n = (px_inc != NPIX_C);
            frame_cnt_n   = frame_cnt + 8'd1;
          end
        end
      end
      S_DONE: begin
        state_n = cont ? S_WAIT_VS : S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    cam_en_n = (state_n == S_CAPTURE);
    busy_n   = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed sequence with randomized pixel traffic, checked against a
// pixel-count/frame-count model of the capture controller.
module tb_capture_ctrl;

  localparam int unsigned AW     = 9;
  localparam int unsigned NPIX   = 300;
  localparam int unsigned DB_CYC = 16;

  logic          pclk, rst, btn, cont, clr_en, vsync, cam_wr;
  logic [AW-1:0] cam_addr, mem_addr;
  logic [7:0]    cam_data, mem_data, frame_cnt;
  logic          cam_en, mem_wr, busy, frame_done, short_frame;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  capture_ctrl #(.AW(AW), .NPIX(NPIX), .DB_CYC(DB_CYC), .CLR_VAL(8'h00)) dut (
    .pclk(pclk), .rst(rst), .btn(btn), .cont(cont), .clr_en(clr_en),
    .vsync(vsync), .cam_wr(cam_wr), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_en(cam_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .frame_done(frame_done), .short_frame(short_frame),
    .frame_cnt(frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cam_en"}, 32'(cam_en), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_short"}, 32'(short_frame), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Hold the button until busy reaches the wanted level, then release it
  task automatic press(input string tag, input bit want);
    bit seen;
    seen = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      chk({tag, "_no_done"}, 32'(frame_done), 32'd0);
      if (busy === want) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
    btn = 1'b0;
  endtask

  // vsync high for a few cycles (with stray cam_wr), then the falling edge
  task automatic vs_start();
    vsync  = 1'b1;
    cam_wr = 1'b1;
    cam_addr = AW'(5);
    repeat (3) begin
      step();
      chk("wait_vs_cam_en", 32'(cam_en), 32'd0);
      chk("wait_vs_mem_wr", 32'(mem_wr), 32'd0);
    end
    cam_wr = 1'b0;
    vsync  = 1'b0;
    step();
    chk("cam_en_after_fall", 32'(cam_en), 32'd1);
  endtask

  // Random pixel traffic; ends on NPIX pixels, on vsync rise at rise_at pixels,
  // or returns mid-frame after stop_at pixels
  task automatic run_capture(input int rise_at, input int stop_at, input bit cont_v);
    int px;
    bit fin, wr, acc, rise;
    logic [AW-1:0] a;
    logic [7:0] d;
    px = 0;
    fin = 1'b0;
    cont = cont_v;
    for (int cyc = 0; cyc < 20 * NPIX && !fin; cyc++) begin
      rise = (rise_at >= 0) && (px == rise_at);
      wr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) != 0) ? AW'(NPIX) : AW'($urandom_range(NPIX, (1 << AW) - 1));
      else
        a = AW'($urandom_range(0, NPIX - 1));
      d = 8'($urandom);
      if (rise) begin
        wr = (rise_at == NPIX - 1);
        a = AW'(NPIX - 1);
        vsync = 1'b1;
      end
      cam_wr = wr;
      cam_addr = a;
      cam_data = d;
      acc = wr && (32'(a) < NPIX);
      step();
      chk("mem_wr", 32'(mem_wr), 32'(acc));
      if (acc) begin
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("mem_data", 32'(mem_data), 32'(d));
      end
      px += int'(acc);
      if (px == NPIX || rise) begin
        model_cnt = (model_cnt + 1) % 256;
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("short_frame", 32'(short_frame), 32'(px != NPIX));
        chk("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
        chk("cam_en_in_done", 32'(cam_en), 32'd0);
        cam_wr = 1'b0;
        step();
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("short_held", 32'(short_frame), 32'(px != NPIX));
        chk("busy_after_done", 32'(busy), 32'(cont_v));
        chk("mem_wr_after_done", 32'(mem_wr), 32'd0);
        fin = 1'b1;
      end else begin
        chk("frame_done_early", 32'(frame_done), 32'd0);
        chk("cam_en_capture", 32'(cam_en), 32'd1);
        if (stop_at > 0 && px == stop_at) fin = 1'b1;
      end
    end
    chk("capture_ended", 32'(fin), 32'd1);
    cam_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; cont = 1'b0; clr_en = 1'b0; vsync = 1'b1;
    cam_wr = 1'b0; cam_addr = '0; cam_data = '0;
    #1;
    chk_all_zero("rst_async");
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_all_zero("rst_release");

    // Single start without clear, then a full frame in single-shot mode
    press("start1", 1'b1);
    for (int i = 0; i < 25; i++) begin
      cam_wr = 1'b1;
      cam_addr = AW'($urandom_range(0, NPIX - 1));
      step();
      chk("one_start_busy", 32'(busy), 32'd1);
      chk("wait_vs_no_wr", 32'(mem_wr), 32'd0);
    end
    cam_wr = 1'b0;
    vs_start();
    run_capture(-1, 0, 1'b0);

    // Clear pass (vsync activity ignored), then three continuous frames
    clr_en = 1'b1;
    vsync = 1'b1;
    press("start_clear", 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      if (i == 50) vsync = 1'b0;
      if (i == 60) vsync = 1'b1;
      chk("clr_wr", 32'(mem_wr), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", 32'(mem_data), 32'd0);
      step();
    end
    chk("clr_end_wr", 32'(mem_wr), 32'd0);
    chk("clr_end_busy", 32'(busy), 32'd1);
    vs_start();
    run_capture(-1, 0, 1'b1);
    vs_start();
    run_capture(100, 0, 1'b1);
    vs_start();
    run_capture(NPIX - 1, 0, 1'b0);
    clr_en = 1'b0;
    repeat (25) step();

    // Abort with a second start at pixel 100
    press("start_abort", 1'b1);
    vs_start();
    run_capture(-1, 100, 1'b0);
    press("abort", 1'b0);
    chk("abort_cam_en", 32'(cam_en), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'(model_cnt));
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cam_wr = 1'b1;
      cam_addr = AW'(i);
      vsync = (i > 4) ? 1'b0 : 1'b1;
      step();
      chk("idle_no_wr", 32'(mem_wr), 32'd0);
      chk("idle_no_en", 32'(cam_en), 32'd0);
    end
    cam_wr = 1'b0;
    repeat (25) step();

    // Bouncing button never produces a start
    for (int i = 0; i < 200; i++) begin
      btn = ((i / 5) % 2) != 0;
      step();
      chk("bounce_idle", 32'(busy), 32'd0);
    end
    btn = 1'b0;
    repeat (25) step();

    // Asynchronous reset in the middle of a frame
    press("start_rst", 1'b1);
    vs_start();
    run_capture(-1, 50, 1'b0);
    cam_wr = 1'b1;
    cam_addr = AW'(7);
    cam_data = 8'hA5;
    step();
    chk("pre_rst_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    step();
    rst = 1'b0;
    cam_wr = 1'b0;
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_wr", 32'(mem_wr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Sequencer and framebuffer write-port owner for the camera capture path.
- Takes the raw capture button and the camera vsync, and gates the pixel-capture block through cam_en.
- Optionally clears the framebuffer before a capture.
- Forwards the capture block's pixel writes to the framebuffer write port, counts them, and reports frame completion.
- Sits between the capture block and the dual-port framebuffer. Runs entirely in the pclk domain.

Parameters:
AW, 15, framebuffer address width
NPIX, 19200, pixels per frame (160x120); must be <= 2**AW
DB_CYC, 16, debounce length in pclk cycles; minimum 2
CLR_VAL, 8'h00, value written during clear

Ports:
pclk  in  1  camera pixel clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
btn  in  1  raw push button; asynchronous to pclk
cont  in  1  1 = continuous capture, 0 = single shot; sampled in DONE
clr_en  in  1  1 = clear framebuffer before the first capture after start
vsync  in  1  camera vsync
cam_wr  in  1  write strobe from the capture block
cam_addr  in  AW  pixel address from the capture block
cam_data  in  8  RGB332 pixel from the capture block
cam_en  out  1  enables the capture block
mem_wr  out  1  framebuffer write enable
mem_addr  out  AW  framebuffer write address
mem_data  out  8  framebuffer write data
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when a frame completes
short_frame  out  1  frame ended by vsync before NPIX pixels; valid with frame_done, held until the next frame_done
frame_cnt  out  8  completed frames; wraps 255->0

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0; synchronizer and debounce state 0.
- Button path:
  - 2-FF synchronizer, then a debouncer: the debounced level changes only after DB_CYC consecutive equal synchronized samples.
  - start = one-cycle pulse on the debounced rising edge.
- vsync edges: vs_d is vsync registered. vs_fall = vs_d & ~vsync; vs_rise = ~vs_d & vsync.
- States and transitions:
  - IDLE:
    - cam_en=0, mem_wr=0.
    - start -> CLEAR if clr_en=1, else WAIT_VS.
  - CLEAR:
    - Writes CLR_VAL to addresses 0..NPIX-1, one per cycle (mem_wr=1 every cycle).
    - Takes exactly NPIX cycles. After the write to NPIX-1, go to WAIT_VS.
    - vsync is ignored in this state.
  - WAIT_VS:
    - cam_en=0.
    - On vs_fall: go to CAPTURE, px_cnt cleared to 0, cam_en=1 from the next cycle.
  - CAPTURE:
    - Each cycle with cam_wr=1 and cam_addr<NPIX: mem_wr/mem_addr/mem_data are registered copies of the strobe, address and data (1-cycle latency), and px_cnt increments.
    - cam_wr with cam_addr>=NPIX is dropped and not counted.
    - Exit when px_cnt reaches NPIX: go to DONE, short_frame=0.
    - Exit on vs_rise with px_cnt<NPIX: go to DONE, short_frame=1.
    - If vs_rise and the write that makes px_cnt=NPIX occur in the same cycle, the pixel is written and short_frame=0.
  - DONE (one cycle):
    - cam_en=0, frame_done=1, frame_cnt+1.
    - If cont=1, go to WAIT_VS (no re-clear); otherwise go to IDLE.
- Abort: start while in CLEAR, WAIT_VS or CAPTURE goes to IDLE next cycle.
  - cam_en=0 and no frame_done.
  - A registered write already in flight still completes.
  - A start arriving in the DONE cycle is ignored.
- cam_wr outside CAPTURE never reaches the framebuffer.
- mem_wr is never high in IDLE, WAIT_VS or DONE, except for the single in-flight registered write at the CAPTURE exit or abort.
- Asynchronous reset mid-frame: immediate return to the reset values, including mem_wr=0.
- px_cnt width is AW+1 bits; no overflow is possible.

Test Plan:
- Reset, then btn held high for 20 cycles (DB_CYC=16), clr_en=0, cont=0 -> exactly one start pulse; WAIT_VS; a vsync high-low produces CAPTURE with cam_en=1 on the cycle after vs_fall.
- clr_en=1, start -> 19200 consecutive cycles of mem_wr=1, mem_data=8'h00, addresses 0..19199 in order; then WAIT_VS.
- Full frame of 19200 cam_wr with cam_addr=0..19199 -> each mem write lags its cam_wr by 1 cycle; frame_done one cycle; short_frame=0; frame_cnt=1; back to IDLE with cont=0.
- cont=1, capture 3 frames, with the 2nd frame's vsync rising after 5000 pixels -> frame_cnt=3; short_frame=1 only with the 2nd frame_done; no CLEAR between frames.
- Abort: second start during CAPTURE at pixel 100 -> IDLE; cam_en=0; no frame_done; frame_cnt unchanged; later cam_wr produces no mem_wr.
- Bounce/edge cases:
  - btn toggling every 5 cycles for 200 cycles -> no start.
  - cam_addr=19200 with cam_wr=1 -> no mem_wr, px_cnt unchanged.
  - rst asserted mid-CAPTURE -> all outputs 0 immediately.
